// File: rtl/spi_reg_bridge_if.sv
// Byte-stream and register-bus bundle between spi_slave, spi_reg_bridge and the register file.
// The master side is the bridge: it consumes rx bytes and drives the register bus.
interface spi_reg_bridge_if #(
    parameter int ADDR_W = 7
) ();
    logic [7:0]        rx_byte;
    logic              rx_valid;
    logic [7:0]        tx_byte;
    logic [ADDR_W-1:0] reg_addr;
    logic [7:0]        reg_wdata;
    logic              reg_we;
    logic              reg_re;
    logic [7:0]        reg_rdata;

    modport master (
        input  rx_byte, rx_valid, reg_rdata,
        output tx_byte, reg_addr, reg_wdata, reg_we, reg_re
    );

    modport slave (
        output rx_byte, rx_valid, reg_rdata,
        input  tx_byte, reg_addr, reg_wdata, reg_we, reg_re
    );
endinterface

// File: rtl/spi_reg_bridge.sv
// Decodes SPI register-access frames (command byte + data bytes) into single-cycle
// register-bus strobes and prefetches read data onto tx_byte for the next SPI byte.
module spi_reg_bridge #(
    parameter int         ADDR_W      = 7,
    parameter logic [7:0] STATUS_BYTE = 8'hA5,
    parameter bit         AUTO_INC    = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cs_n,
    spi_reg_bridge_if.master bus,
    output logic             frame_active,
    output logic             frame_done
);
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CMD      = 3'd1,
        WR_DATA  = 3'd2,
        RD_FETCH = 3'd3,
        RD_DATA  = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic              cs_meta_q, cs_sync_q;
    logic [1:0]        sync_vld_q;
    logic              cs_dly_q, cs_dly_d;
    logic              cs_fall_s, cs_rise_s, accept_s;
    logic [7:0]        tx_byte_q, tx_byte_d;
    logic [ADDR_W-1:0] reg_addr_q, reg_addr_d;
    logic [7:0]        reg_wdata_q, reg_wdata_d;
    logic              reg_we_q, reg_we_d;
    logic              reg_re_q, reg_re_d;
    logic              frame_active_q, frame_active_d;
    logic              frame_done_q, frame_done_d;
    logic              cap_q, cap_d;
    logic              close_q, close_d;

    function automatic logic [ADDR_W-1:0] addr_step(input logic [ADDR_W-1:0] a);
        if (AUTO_INC) begin
            addr_step = a + {{(ADDR_W-1){1'b0}}, 1'b1};
        end else begin
            addr_step = a;
        end
    endfunction

    // cs_n synchroniser; sync_vld_q marks when cs_sync_q reflects a real pad sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_meta_q  <= 1'b1;
            cs_sync_q  <= 1'b1;
            sync_vld_q <= 2'b00;
            cs_dly_q   <= 1'b0;
        end else begin
            cs_meta_q  <= cs_n;
            cs_sync_q  <= cs_meta_q;
            sync_vld_q <= {sync_vld_q[0], 1'b1};
            cs_dly_q   <= cs_dly_d;
        end
    end

    // cs_dly_q only goes high once cs has really been seen high, so a frame
    // already in progress at reset release never produces a falling edge
    always_comb begin
        cs_dly_d = 1'b0;
        if (sync_vld_q[1]) begin
            cs_dly_d = cs_sync_q;
        end else begin
            cs_dly_d = 1'b0;
        end
        cs_fall_s = cs_dly_q & ~cs_sync_q;
        cs_rise_s = ~cs_dly_q & cs_sync_q;
        accept_s  = bus.rx_valid & ((state_q == CMD) | (state_q == WR_DATA) | (state_q == RD_DATA));
    end

    // Frame FSM and registered bus outputs
    always_comb begin
        state_d      = state_q;
        tx_byte_d    = tx_byte_q;
        reg_addr_d   = reg_addr_q;
        reg_wdata_d  = reg_wdata_q;
        reg_we_d     = 1'b0;
        reg_re_d     = 1'b0;
        frame_done_d = 1'b0;
        cap_d        = reg_re_q;
        close_d      = 1'b0;

        if (reg_we_q) begin
            reg_addr_d = addr_step(reg_addr_q);
        end else begin
            reg_addr_d = reg_addr_q;
        end
        if (cap_q) begin
            tx_byte_d = bus.reg_rdata;
        end else begin
            tx_byte_d = tx_byte_q;
        end

        if (close_q || (cs_rise_s && (state_q != IDLE) && !accept_s)) begin
            // End of frame: any read data still in flight is dropped
            state_d   = IDLE;
            tx_byte_d = STATUS_BYTE;
            cap_d     = 1'b0;
            if (state_q != CMD) begin
                frame_done_d = 1'b1;
            end else begin
                frame_done_d = 1'b0;
            end
        end else begin
            close_d = cs_rise_s & accept_s;
            case (state_q)
                IDLE: begin
                    if (cs_fall_s) begin
                        state_d = CMD;
                    end else begin
                        state_d = IDLE;
                    end
                end
                CMD: begin
                    if (bus.rx_valid) begin
                        reg_addr_d = bus.rx_byte[ADDR_W-1:0];
                        if (bus.rx_byte[7]) begin
                            state_d  = RD_FETCH;
                            reg_re_d = 1'b1;
                        end else begin
                            state_d  = WR_DATA;
                        end
                    end else begin
                        state_d = CMD;
                    end
                end
                WR_DATA: begin
                    if (bus.rx_valid) begin
                        reg_wdata_d = bus.rx_byte;
                        reg_we_d    = 1'b1;
                    end else begin
                        reg_we_d    = 1'b0;
                    end
                end
                RD_FETCH: begin
                    state_d = RD_DATA;
                end
                RD_DATA: begin
                    if (bus.rx_valid) begin
                        reg_addr_d = addr_step(reg_addr_q);
                        reg_re_d   = 1'b1;
                    end else begin
                        reg_re_d   = 1'b0;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        frame_active_d = (state_d != IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            tx_byte_q      <= STATUS_BYTE;
            reg_addr_q     <= {ADDR_W{1'b0}};
            reg_wdata_q    <= 8'h00;
            reg_we_q       <= 1'b0;
            reg_re_q       <= 1'b0;
            frame_active_q <= 1'b0;
            frame_done_q   <= 1'b0;
            cap_q          <= 1'b0;
            close_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            tx_byte_q      <= tx_byte_d;
            reg_addr_q     <= reg_addr_d;
            reg_wdata_q    <= reg_wdata_d;
            reg_we_q       <= reg_we_d;
            reg_re_q       <= reg_re_d;
            frame_active_q <= frame_active_d;
            frame_done_q   <= frame_done_d;
            cap_q          <= cap_d;
            close_q        <= close_d;
        end
    end

    assign bus.tx_byte   = tx_byte_q;
    assign bus.reg_addr  = reg_addr_q;
    assign bus.reg_wdata = reg_wdata_q;
    assign bus.reg_we    = reg_we_q;
    assign bus.reg_re    = reg_re_q;
    assign frame_active  = frame_active_q;
    assign frame_done    = frame_done_q;
endmodule

// File: tb/tb_spi_reg_bridge.sv
// Bench for spi_reg_bridge: two instances (auto-increment and fixed address) share one
// SPI byte stream; a frame-level model predicts bus transactions, MISO bytes and frame_done.
module tb_spi_reg_bridge;
    localparam int         ADDR_W = 7;
    localparam logic [7:0] STATUS = 8'hA5;

    typedef logic [7:0] bytes_t [$];
    typedef struct packed {
        logic       inst;
        logic       wr;
        logic [6:0] addr;
        logic [7:0] data;
    } ev_t;

    logic clk      = 1'b0;
    logic rst_n    = 1'b0;
    logic cs_n     = 1'b1;
    logic mem_init = 1'b0;
    logic fa0, fd0, fa1, fd1;

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] mem     [2][128];
    logic [7:0] ref_mem [2][128];
    ev_t        evq [$];
    int         done_cnt0 = 0;
    int         done_cnt1 = 0;
    int         excl_bad  = 0;

    always #5 clk = ~clk;

    spi_reg_bridge_if #(.ADDR_W(ADDR_W)) bus0 ();
    spi_reg_bridge_if #(.ADDR_W(ADDR_W)) bus1 ();

    spi_reg_bridge #(.ADDR_W(ADDR_W), .STATUS_BYTE(STATUS), .AUTO_INC(1'b1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .bus(bus0.master),
        .frame_active(fa0), .frame_done(fd0));

    spi_reg_bridge #(.ADDR_W(ADDR_W), .STATUS_BYTE(STATUS), .AUTO_INC(1'b0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .bus(bus1.master),
        .frame_active(fa1), .frame_done(fd1));

    // Register files: read data is junk except in the cycle after reg_re
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 128; i++) begin
                mem[0][i] <= ref_mem[0][i];
                mem[1][i] <= ref_mem[1][i];
            end
        end else begin
            if (bus0.reg_we) mem[0][bus0.reg_addr] <= bus0.reg_wdata;
            if (bus1.reg_we) mem[1][bus1.reg_addr] <= bus1.reg_wdata;
        end
        bus0.reg_rdata <= bus0.reg_re ? mem[0][bus0.reg_addr] : 8'($urandom);
        bus1.reg_rdata <= bus1.reg_re ? mem[1][bus1.reg_addr] : 8'($urandom);
    end

    // Bus monitor
    always @(negedge clk) begin
        if (bus0.reg_we) evq.push_back('{1'b0, 1'b1, bus0.reg_addr, bus0.reg_wdata});
        if (bus0.reg_re) evq.push_back('{1'b0, 1'b0, bus0.reg_addr, 8'h00});
        if (bus1.reg_we) evq.push_back('{1'b1, 1'b1, bus1.reg_addr, bus1.reg_wdata});
        if (bus1.reg_re) evq.push_back('{1'b1, 1'b0, bus1.reg_addr, 8'h00});
        if (fd0) done_cnt0 <= done_cnt0 + 1;
        if (fd1) done_cnt1 <= done_cnt1 + 1;
        if ((bus0.reg_we && bus0.reg_re) || (bus1.reg_we && bus1.reg_re)) excl_bad <= excl_bad + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic pulse_rx(input logic [7:0] b);
        bus0.rx_byte  = b;
        bus1.rx_byte  = b;
        bus0.rx_valid = 1'b1;
        bus1.rx_valid = 1'b1;
        @(posedge clk); #1;
        bus0.rx_valid = 1'b0;
        bus1.rx_valid = 1'b0;
    endtask

    // One SPI frame; late_last makes the final byte coincide with the cs rising edge
    task automatic run_frame(input bytes_t b, input bit late_last);
        int         n   = b.size();
        int         ev0 = evq.size();
        int         d0  = done_cnt0;
        int         d1  = done_cnt1;
        int         x0  = excl_bad;
        logic [7:0] miso [2][$];
        cs_n = 1'b0;
        repeat (6) @(posedge clk); #1;
        check("frame_active", {30'd0, fa0, fa1}, 32'd3);
        for (int k = 0; k < n; k++) begin
            repeat (8) @(posedge clk); #1;
            miso[0].push_back(bus0.tx_byte);
            miso[1].push_back(bus1.tx_byte);
            if (late_last && (k == n - 1)) begin
                cs_n = 1'b1;
                repeat (2) @(posedge clk); #1;
            end else begin
                repeat (8) @(posedge clk); #1;
            end
            pulse_rx(b[k]);
        end
        if (!(late_last && (n > 0))) begin
            repeat (16) @(posedge clk); #1;
            cs_n = 1'b1;
        end
        repeat (10) @(posedge clk); #1;
        check("idle_active", {30'd0, fa0, fa1}, 32'd0);
        check("idle_tx0", bus0.tx_byte, STATUS);
        check("idle_tx1", bus1.tx_byte, STATUS);
        check("done0", done_cnt0 - d0, (n > 0) ? 1 : 0);
        check("done1", done_cnt1 - d1, (n > 0) ? 1 : 0);
        check("we_re_excl", excl_bad - x0, 0);

        for (int i = 0; i < 2; i++) begin
            ev_t        exp_q [$];
            ev_t        got_q [$];
            logic [7:0] exp_miso [$];
            logic [6:0] a;
            logic [6:0] step;
            step = (i == 0) ? 7'd1 : 7'd0;
            a    = 7'd0;
            if (n > 0) begin
                a = b[0][6:0];
                exp_miso.push_back(STATUS);
                if (b[0][7]) exp_q.push_back('{i[0], 1'b0, a, 8'h00});
                for (int k = 1; k < n; k++) begin
                    if (b[0][7]) begin
                        exp_miso.push_back(ref_mem[i][a]);
                        a = a + step;
                        exp_q.push_back('{i[0], 1'b0, a, 8'h00});
                    end else begin
                        exp_miso.push_back(STATUS);
                        exp_q.push_back('{i[0], 1'b1, a, b[k]});
                        ref_mem[i][a] = b[k];
                        a = a + step;
                    end
                end
            end
            for (int j = ev0; j < evq.size(); j++) begin
                if (evq[j].inst == i[0]) got_q.push_back(evq[j]);
            end
            check("n_events", got_q.size(), exp_q.size());
            for (int j = 0; (j < exp_q.size()) && (j < got_q.size()); j++)
                check("event", 32'(got_q[j]), 32'(exp_q[j]));
            for (int j = 0; j < n; j++)
                check("miso", miso[i][j], exp_miso[j]);
        end
    endtask

    initial begin
        bytes_t fr;
        int     ev_mark, dm0, dm1, len;
        bus0.rx_byte  = 8'h00;
        bus1.rx_byte  = 8'h00;
        bus0.rx_valid = 1'b0;
        bus1.rx_valid = 1'b0;
        for (int i = 0; i < 2; i++)
            for (int a = 0; a < 128; a++) ref_mem[i][a] = 8'($urandom);
        mem_init = 1'b1;
        repeat (3) @(posedge clk); #1;
        mem_init = 1'b0;

        check("rst_tx0", bus0.tx_byte, STATUS);
        check("rst_tx1", bus1.tx_byte, STATUS);
        check("rst_addr", bus0.reg_addr, 7'd0);
        check("rst_wdata", bus0.reg_wdata, 8'd0);
        check("rst_strobes", {bus0.reg_we, bus0.reg_re, bus1.reg_we, bus1.reg_re}, 4'd0);
        check("rst_frame", {fa0, fd0, fa1, fd1}, 4'd0);
        rst_n = 1'b1;
        repeat (5) @(posedge clk); #1;

        fr = {8'h05, 8'h11, 8'h22};
        run_frame(fr, 1'b0);
        check("wr_05", mem[0][5], 8'h11);
        check("wr_06", mem[0][6], 8'h22);
        check("wr_fixed", mem[1][5], 8'h22);

        fr = {8'h10, 8'h3C, 8'h7E};
        run_frame(fr, 1'b0);
        fr = {8'h90, 8'h00, 8'h00};
        run_frame(fr, 1'b0);

        fr = {8'h7F, 8'hAA, 8'hBB};
        run_frame(fr, 1'b0);
        check("wrap_7f", mem[0][127], 8'hAA);
        check("wrap_00", mem[0][0], 8'hBB);

        fr = {8'h83, 8'h00, 8'h00, 8'h00};
        run_frame(fr, 1'b0);

        fr = {8'h05};
        run_frame(fr, 1'b0);
        fr = {};
        run_frame(fr, 1'b0);

        fr = {8'h21, 8'h9C};
        run_frame(fr, 1'b1);
        check("late_wr", mem[0][33], 8'h9C);
        fr = {8'h85, 8'h00};
        run_frame(fr, 1'b1);
        fr = {8'h44};
        run_frame(fr, 1'b1);

        for (int r = 0; r < 12; r++) begin
            fr  = {};
            len = $urandom_range(0, 5);
            for (int k = 0; k < len; k++) fr.push_back(8'($urandom));
            run_frame(fr, (len > 0) && ($urandom_range(0, 1) == 1));
        end

        // Reset during a read data phase with cs_n held low throughout
        cs_n = 1'b0;
        repeat (6) @(posedge clk); #1;
        repeat (16) @(posedge clk); #1;
        pulse_rx(8'h90);
        repeat (16) @(posedge clk); #1;
        pulse_rx(8'h00);
        rst_n = 1'b0;
        #1;
        check("mid_rst_tx", bus0.tx_byte, STATUS);
        check("mid_rst_re", {bus0.reg_re, bus1.reg_re}, 2'd0);
        check("mid_rst_addr", bus0.reg_addr, 7'd0);
        check("mid_rst_active", {fa0, fa1}, 2'd0);
        repeat (3) @(posedge clk); #1;
        rst_n   = 1'b1;
        ev_mark = evq.size();
        dm0     = done_cnt0;
        dm1     = done_cnt1;
        repeat (6) @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            repeat (16) @(posedge clk); #1;
            pulse_rx((k == 0) ? 8'h02 : 8'h55);
        end
        repeat (16) @(posedge clk); #1;
        cs_n = 1'b1;
        repeat (10) @(posedge clk); #1;
        check("post_rst_events", evq.size() - ev_mark, 0);
        check("post_rst_done", (done_cnt0 - dm0) + (done_cnt1 - dm1), 0);
        fr = {8'h02, 8'h55};
        run_frame(fr, 1'b0);
        check("post_rst_wr0", mem[0][2], 8'h55);
        check("post_rst_wr1", mem[1][2], 8'h55);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/spi_reg_bridge.md
Name: spi_reg_bridge

Overview:
- Downstream protocol stage for spi_slave. Consumes the received byte stream (rx_byte/rx_valid) plus cs_n, decodes register-access frames from the ESP32, and drives a simple register-file bus.
- Supplies tx_byte back to spi_slave so that read data is shifted out on MISO during the following byte.
- Frame format: byte 0 is the command (bit7 = 1 read / 0 write, bits[6:0] = start address); bytes 1..N are data. Address auto-increments per data byte. A frame ends on cs_n deassertion.

Parameters:
- ADDR_W, 7, register address width; equals command bits used, max 7.
- STATUS_BYTE, 8'hA5, value presented on tx_byte outside read data phases.
- AUTO_INC, 1, 1 = increment address after every data byte; 0 = fixed address (FIFO-style register).

Ports:
- clk  in  1  system clock, 100 MHz.
- rst_n  in  1  asynchronous active-low reset.
- cs_n  in  1  raw SPI chip select from pad, asynchronous; synchronised internally with 2 flops.
- rx_byte  in  8  byte from spi_slave, valid when rx_valid is high.
- rx_valid  in  1  one-cycle strobe from spi_slave.
- tx_byte  out  8  byte spi_slave shifts out during the next SPI byte.
- reg_addr  out  ADDR_W  register bus address.
- reg_wdata  out  8  register write data.
- reg_we  out  1  one-cycle write strobe.
- reg_re  out  1  one-cycle read strobe.
- reg_rdata  in  8  read data, valid exactly 1 cycle after reg_re.
- frame_active  out  1  high while a frame is in progress.
- frame_done  out  1  one-cycle pulse when a frame that contained at least a command byte ends.

Behaviour:
- Reset: all state async-cleared. FSM = IDLE; tx_byte = STATUS_BYTE; reg_addr, reg_wdata = 0; reg_we, reg_re, frame_active, frame_done = 0. Synchroniser flops reset to 1 (inactive).
- cs_sync is the 2-flop synchronised cs_n. A frame starts only on a detected 1->0 edge of cs_sync. If cs_n is low when reset releases, the partial frame is ignored until cs_n rises and falls again.
- FSM states: IDLE, CMD, WR_DATA, RD_FETCH, RD_DATA.
- IDLE: rx_valid is ignored. On cs_sync falling edge -> CMD, frame_active = 1.
- CMD, on rx_valid:
  - reg_addr <= rx_byte[ADDR_W-1:0].
  - If bit7 = 0 -> WR_DATA.
  - If bit7 = 1 -> RD_FETCH, with reg_re = 1 in the cycle RD_FETCH is entered.
- RD_FETCH: one cycle wait. Then tx_byte <= reg_rdata -> RD_DATA. tx_byte is stable 3 clk cycles after the command's rx_valid, which is well within one SCLK half-period at supported SPI rates.
- RD_DATA, on rx_valid (received byte is a don't-care dummy):
  - If AUTO_INC, reg_addr increments.
  - reg_re pulses and the next value is loaded into tx_byte 2 cycles later (prefetch for the following byte).
- WR_DATA, on rx_valid: reg_wdata <= rx_byte, reg_we = 1 for one cycle with the current reg_addr. The address increments in the cycle after the reg_we pulse, if AUTO_INC.
- Address wrap: 2^ADDR_W-1 increments to 0, with no error flag.
- cs_sync rising edge in any non-IDLE state:
  - -> IDLE, tx_byte <= STATUS_BYTE, frame_active = 0.
  - frame_done pulses 1 cycle if the state was not CMD, i.e. a command byte was received.
  - An outstanding reg_rdata capture from RD_FETCH/RD_DATA is discarded.
- Simultaneous rx_valid and cs_sync rising edge: the byte is processed first (a write is committed and reg_we still pulses that cycle), then IDLE on the next cycle. frame_done is then asserted 1 cycle later.
- reg_we and reg_re are never high in the same cycle.
- At most one reg_we or reg_re is issued per rx_valid.
- Async reset mid-frame: no further strobes are issued and outputs return to reset values immediately.

Test Plan:
- Write frame: cs_n low, send 0x05, 0x11, 0x22, cs_n high -> reg_we pulses twice: (addr 0x05, data 0x11) then (addr 0x06, data 0x22); frame_done = 1 once; tx_byte = 0xA5 throughout.
- Read frame: regfile holds addr 0x10 = 0x3C, addr 0x11 = 0x7E. Send 0x90, 0x00, 0x00 -> MISO bytes are 0xA5, 0x3C, 0x7E; reg_re pulses at addr 0x10, 0x11, 0x12.
- Wrap: write command 0x7F with 2 data bytes 0xAA, 0xBB -> writes land at 0x7F then 0x00.
- AUTO_INC = 0: read command 0x83 with 3 dummies -> all reg_re at addr 0x03.
- Abort: cs_n high after command byte only (0x05) -> no reg_we, frame_done = 1, tx_byte = 0xA5. cs_n high with no bytes sent -> frame_done = 0.
- Reset mid-read: assert rst_n low during RD_DATA with cs_n held low, then release -> reg_re stays 0 and no bytes are accepted until cs_n goes high then low. A new frame 0x02, 0x55 then writes 0x55 to addr 0x02.
